// File: rtl/piso_pkg.sv
// Shared definitions for the PISO shift-register sequencer: register op codes
// and the controller state encoding.
package piso_pkg;

  // Op codes understood by the shift-register datapath.
  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  // Controller states. The encoding is also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/piso_seq_ctrl_if.sv
// Requester-side bundle of the PISO sequencer.
//
// Handshake: a word is accepted on a rising clk_i edge where start_i and
// ready_o are both high. The requester keeps start_i (and the word on the
// register's d_i) stable until that edge; start_i seen while ready_o is low
// is ignored and never latched. div_i is sampled only on the accepting edge.
interface piso_seq_ctrl_if #(
  parameter int Width = 8,
  parameter int DivW  = 16
);
  logic                     start_i;
  logic                     ready_o;
  logic [DivW-1:0]          div_i;
  logic                     abort_i;
  logic [1:0]               op_o;
  logic                     busy_o;
  logic                     bit_valid_o;
  logic [$clog2(Width)-1:0] bit_idx_o;
  logic                     done_o;
  piso_pkg::state_e         state_o;  // debug view of the controller FSM

  // Requester side: drives the request, observes the sequencer.
  modport master (
    output start_i, div_i, abort_i,
    input  ready_o, op_o, busy_o, bit_valid_o, bit_idx_o, done_o, state_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, div_i, abort_i,
    output ready_o, op_o, busy_o, bit_valid_o, bit_idx_o, done_o, state_o
  );
endinterface

// File: rtl/piso_seq_ctrl_bit_period_cnt.sv
// Loadable down-counter used to pace one serial bit every (load value + 1)
// clocks. Clear beats load, load beats decrement; it parks at zero.
module bit_period_cnt #(
  parameter int DivW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [DivW-1:0] i_load_val,
  input  logic            i_en,
  output logic            o_zero
);

  logic [DivW-1:0] r_count;

  // Counter register: clear, reload, or count down toward zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/piso_seq_ctrl.sv
// Sequencer for the parallel-in serial-out shift register. Accepts a word via
// start_i/ready_o, issues load/shift/clear op codes, holds each bit for
// (div+1) clocks, and pulses done_o after the last bit.
module piso_seq_ctrl
  import piso_pkg::*;
#(
  parameter int Width = 8,
  parameter int DivW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  piso_seq_ctrl_if.slave   bus
);

  localparam int IdxW = $clog2(Width);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Width - 1);

  state_e            r_state;
  logic [IdxW-1:0]   r_bit_cnt;
  logic [DivW-1:0]   r_div;

  state_e            w_state_nxt;
  logic              w_cnt_zero;
  logic              w_cnt_clr;
  logic              w_cnt_load;
  logic [DivW-1:0]   w_cnt_load_val;
  logic              w_cnt_en;
  logic              w_bit_inc;
  logic              w_bit_clr;
  logic              w_div_latch;
  logic [1:0]        w_op;
  logic              w_ready;
  logic              w_busy;
  logic              w_bit_valid;
  logic              w_done;

  bit_period_cnt #(
    .DivW (DivW)
  ) u_period (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  // State register plus bit counter and the divider latched at accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_div     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_div_latch) begin
        r_div <= bus.div_i;
      end
    end
  end

  // Next state, op code and status outputs; load op is Mealy on accept.
  always_comb begin
    w_state_nxt    = r_state;
    w_op           = OP_HOLD;
    w_ready        = 1'b0;
    w_busy         = 1'b0;
    w_bit_valid    = 1'b0;
    w_done         = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = r_div;
    w_cnt_en       = 1'b0;
    w_bit_inc      = 1'b0;
    w_bit_clr      = 1'b0;
    w_div_latch    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.start_i) begin
          w_op           = OP_LOAD;
          w_state_nxt    = ST_SHIFT;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = bus.div_i;
          w_bit_clr      = 1'b1;
          w_div_latch    = 1'b1;
        end
      end

      ST_SHIFT: begin
        w_busy      = 1'b1;
        w_bit_valid = 1'b1;
        if (bus.abort_i) begin
          // Abort wins over terminal count; wipe the register and counters.
          w_op        = OP_CLR;
          w_state_nxt = ST_IDLE;
          w_cnt_clr   = 1'b1;
          w_bit_clr   = 1'b1;
        end else if (w_cnt_zero) begin
          if (r_bit_cnt != LastIdx) begin
            w_op       = OP_SHIFT;
            w_bit_inc  = 1'b1;
            w_cnt_load = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        w_op        = OP_CLR;
        w_done      = 1'b1;
        w_busy      = 1'b1;
        w_bit_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.ready_o     = w_ready;
  assign bus.op_o        = w_op;
  assign bus.busy_o      = w_busy;
  assign bus.bit_valid_o = w_bit_valid;
  assign bus.bit_idx_o   = (r_state == ST_SHIFT) ? r_bit_cnt : '0;
  assign bus.done_o      = w_done;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Bench for piso_seq_ctrl: directed scenarios plus random words, with a
// behavioural shift register driven by op_o and a queue of expected events.
module tb_piso_seq_ctrl;
  import piso_pkg::*;

  localparam int W  = 8;
  localparam int DW = 16;
  localparam int IW = $clog2(W);

  localparam logic [31:0] TAG_BIT   = 32'h100;
  localparam logic [31:0] TAG_DONE  = 32'h200;
  localparam logic [31:0] TAG_ABORT = 32'h300;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  piso_seq_ctrl_if #(.Width(W), .DivW(DW)) bus ();

  piso_seq_ctrl #(.Width(W), .DivW(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  logic [W-1:0]  r_d;      // word presented on the register's d_i
  logic [W-1:0]  sh;       // behavioural shift register
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];
  int            done_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Shift-register datapath model obeying the op code.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sh <= '0;
    else begin
      case (bus.op_o)
        OP_LOAD:  sh <= r_d;
        OP_SHIFT: sh <= sh << 1;
        OP_CLR:   sh <= '0;
        default:  sh <= sh;
      endcase
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  // Expected observable events of one accepted word, from the transfer rules.
  task automatic push_expect(input logic [W-1:0] d, input int div, input int abort_at,
                             input int acc);
    int total = W * (div + 1);
    int n = (abort_at > 0) ? abort_at : total;
    for (int c = 0; c < n; c++) begin
      int idx = c / (div + 1);
      exp_q.push_back(TAG_BIT | (32'(idx) << 1) | 32'(d[W-1-idx]));
    end
    if (abort_at > 0) exp_q.push_back(TAG_ABORT);
    else begin
      exp_q.push_back(TAG_DONE);
      done_q.push_back(acc + total + 1);
    end
  endtask

  // Wait (bounded) for a negedge where ready_o is high; returns 0 on timeout.
  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk_i);
    while (!bus.ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    ok = bus.ready_o;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: ready_o stayed 0 (cycle %0d)", cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic xfer(input logic [W-1:0] d, input int div, input int abort_at);
    bit ok;
    int acc;
    r_d = d;
    bus.div_i = DW'(div);
    bus.start_i = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      bus.start_i = 1'b0;
      return;
    end
    chk("mealy_load", 32'(bus.op_o), 32'(OP_LOAD));
    acc = cyc;
    push_expect(d, div, abort_at, acc);
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    bus.div_i = DW'($urandom_range(0, 7));  // must not disturb the word
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk_i);
      #1;
      bus.abort_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.abort_i = 1'b0;
      chk("ready_after_abort", 32'(bus.ready_o), 32'd1);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ready"}, 32'(bus.ready_o), 32'd1);
    chk({name, "_op"}, 32'(bus.op_o), 32'(OP_HOLD));
    chk({name, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({name, "_bit_valid"}, 32'(bus.bit_valid_o), 32'd0);
    chk({name, "_bit_idx"}, 32'(bus.bit_idx_o), 32'd0);
    chk({name, "_done"}, 32'(bus.done_o), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("ready_vs_busy", 32'(bus.ready_o), 32'(!bus.busy_o));
      if (bus.op_o == OP_LOAD)
        chk("load_only_on_accept", 32'(bus.ready_o & bus.start_i), 32'd1);
      if (bus.done_o) begin
        chk("done_shape", {27'd0, bus.op_o, bus.bit_valid_o, bus.busy_o, 1'b0},
            {27'd0, OP_CLR, 1'b0, 1'b1, 1'b0});
        pop_chk("done_event", TAG_DONE);
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_unexpected: got done_o=1 expected none (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
      end else if (bus.bit_valid_o) begin
        pop_chk("serial_bit", TAG_BIT | (32'(bus.bit_idx_o) << 1) | 32'(sh[W-1]));
        if (bus.op_o == OP_CLR) pop_chk("abort_event", TAG_ABORT);
      end else begin
        chk("idle_bit_idx", 32'(bus.bit_idx_o), 32'd0);
        chk("idle_op_no_shift_clr", 32'(bus.op_o[1]), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int acc1, acc2;
    rst_i = 1'b1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.div_i = '0;
    r_d = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle_outputs("reset");
    rst_i = 1'b0;

    // Directed words from the test plan.
    xfer(8'hA5, 0, 0);
    xfer(8'h81, 2, 0);
    xfer(8'h3C, 1, 0);

    // start_i held high: accepts exactly one transfer period apart.
    r_d = 8'hA5;
    bus.div_i = '0;
    bus.start_i = 1'b1;
    wait_ready(ok);
    acc1 = cyc;
    push_expect(8'hA5, 0, 0, acc1);
    @(posedge clk_i);
    #1;
    wait_ready(ok);
    acc2 = cyc;
    push_expect(8'hA5, 0, 0, acc2);
    chk("held_start_spacing", 32'(acc2 - acc1), 32'(W + 2));
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;

    // Abort on the 4th SHIFT cycle, and on the very last one.
    xfer(8'hC3, 0, 4);
    xfer(8'h5A, 1, W * 2);

    // Asynchronous reset mid-transfer, then a normal transfer.
    xfer(8'hF0, 1, 0);
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    exp_q.delete();
    done_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    xfer(8'h96, 0, 0);

    // Random words, dividers and occasional aborts.
    for (int i = 0; i < 24; i++) begin
      int div = $urandom_range(0, 3);
      int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W * (div + 1)) : 0;
      xfer(W'($urandom), div, ab);
    end

    // Drain outstanding expectations.
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
